xor_acc_arbiter: RTL and testbench
==================================

Name: xor_acc_arbiter

Overview:
Round-robin arbiter and sequencer that shares one XOR-feedback accumulator register among NREQ requesters. Each accepted word updates the register as acc <= acc ^ data. The block owns the accumulator, the grant logic, an optional burst lock and an operation counter. It sits between requester-side producers and any consumer of the running XOR value.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data and accumulator width in bits
MAXBURST, 4, maximum consecutive grants for one locked owner (>=1)
COUNT_W, 16, width of the saturating operation counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
clr  input  1  synchronous accumulator clear request
req_valid  input  NREQ  per-requester word valid
req_lock  input  NREQ  per-requester burst-lock request, sampled when that requester is granted
req_data  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot grant, combinational; the word is accepted when valid && ready
acc  output  WIDTH  accumulator value (registered)
acc_upd  output  1  registered pulse, high in the cycle the new acc becomes visible
gnt_id  output  clog2(NREQ)  index of the last accepted requester (registered)
op_count  output  COUNT_W  number of accepted words, saturating

Behaviour:
- Reset (reset=0, any time, asynchronous): clears acc, acc_upd, gnt_id, op_count, the round-robin pointer ptr, owner and burst_cnt to 0. State goes to IDLE. req_ready is 0 while reset=0.
- Latency: a word accepted at edge k appears on acc after edge k, with acc_upd=1 for that one cycle. There is no extra pipeline stage.
- req_ready is at most one-hot. It is never asserted to a requester whose req_valid=0. It depends only on req_valid, clr and registered state, and never on req_data.
- clr has priority in every state:
  - acc <= 0.
  - All req_ready=0 that cycle.
  - acc_upd=0.
  - State, owner, burst_cnt and ptr do not change.
- IDLE (clr=0):
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, … modulo NREQ.
  - On a grant: acc <= acc ^ data[winner]; gnt_id <= winner; ptr <= (winner+1) mod NREQ; op_count increments.
  - If req_lock[winner]=1 and MAXBURST>1: go to OWN with owner=winner and burst_cnt=1. Otherwise stay in IDLE.
  - No valid requester: no change.
- OWN (clr=0): only the owner can be granted.
  - Owner valid: accept the word as above and increment burst_cnt. ptr stays at owner+1.
  - Return to IDLE when req_lock[owner]=0 at the accepting edge, or when burst_cnt reaches MAXBURST.
  - Owner not valid and req_lock[owner]=0: return to IDLE with no grant. Arbitration resumes the next cycle.
  - Owner not valid and req_lock[owner]=1: stay in OWN and wait. Other requesters are stalled.
- op_count saturates at 2^COUNT_W-1 and never wraps. clr does not reset it.
- Pointer wrap: ptr = NREQ-1 followed by a grant to NREQ-1 gives ptr=0.
- All arithmetic is unsigned. XOR is bitwise, full WIDTH, with no carry.

Decomposition:
- Shared package xor_acc_pkg holds:
  - the state encoding (IDLE=1'b0, OWN=1'b1)
  - a clog2 function
  - default width constants
- One natural sub-module, rr_picker: a purely combinational rotate-priority one-hot select from valid vector and ptr. It outputs onehot and index, and is reused by other shared-resource arbiters.

Test Plan:
- Reset mid-operation: hold req0 valid with data 0x3C for 3 cycles, then pull reset low between edges. acc, gnt_id, op_count and req_ready go to 0 immediately (no clock needed). After release, the first grant goes to req0.
- Single requester: req0 sends 0xA5, then 0x0F, on consecutive cycles. acc reads 0xA5 then 0xAA, acc_upd is high for 2 cycles, gnt_id=0 and op_count=2.
- Round robin: all four valid, unlocked, data 0x01/0x02/0x04/0x08 held. Grant order is 0,1,2,3,0. acc reads 0x0F after four grants and 0x0E after the fifth.
- Burst lock: req2 valid with lock=1 and req1 valid, ptr=2. Expect four consecutive grants to req2 (MAXBURST=4), then return to IDLE with ptr=3. The next grant goes to req3 if it is valid, otherwise to req1.
- Clear collision: clr=1 while req0 is valid with 0x55 and acc=0xFF. That cycle gives acc=0x00 and req_ready=0. The next cycle grants req0 and acc becomes 0x55.
- Saturation: COUNT_W=4, accept 17 words. op_count stops at 15 and the accumulator keeps updating.

Source files
------------

// File: rtl/xor_acc_arbiter_pkg.sv
// Shared types and constants for the XOR-accumulator arbiter and its round-robin picker.
package xor_acc_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAXBURST = 4;
  localparam int DEF_COUNT_W  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/xor_acc_arbiter_rr_picker.sv
// Rotate-priority picker: first valid bit at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int i;
    i      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any && valid[i]) begin
        any       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/xor_acc_arbiter.sv
// Round-robin arbiter sharing one XOR-feedback accumulator, with optional burst lock
// and a saturating count of accepted words.
module xor_acc_arbiter
  import xor_acc_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAXBURST = DEF_MAXBURST,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         acc,
  output logic                     acc_upd,
  output logic [idx_w(NREQ)-1:0]   gnt_id,
  output logic [COUNT_W-1:0]       op_count
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = idx_w(MAXBURST + 1);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, owner, owner_n;
  logic [BW-1:0]   burst_cnt, burst_n;

  logic [NREQ-1:0] pick_oh, ready_c;
  logic [IW-1:0]   pick_idx, win;
  logic            pick_any, grant;
  logic [WIDTH-1:0] win_data;

  rr_picker #(.N(NREQ), .IW(IW)) u_pick (
    .valid  (req_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // clr wins everything: no grant, and the lock/pointer state is left untouched.
  always_comb begin
    ready_c = '0;
    grant   = 1'b0;
    win     = pick_idx;
    state_n = state;
    owner_n = owner;
    burst_n = burst_cnt;
    if (!clr) begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            ready_c = pick_oh;
            grant   = 1'b1;
            if (req_lock[pick_idx] && MAXBURST > 1) begin
              state_n = OWN;
              owner_n = pick_idx;
              burst_n = BW'(1);
            end
          end
        end
        OWN: begin
          win = owner;
          if (req_valid[owner]) begin
            ready_c[owner] = 1'b1;
            grant          = 1'b1;
            burst_n        = burst_cnt + BW'(1);
            if (!req_lock[owner] || int'(burst_cnt) + 1 >= MAXBURST) begin
              state_n = IDLE;
              burst_n = '0;
            end
          end else if (!req_lock[owner]) begin
            state_n = IDLE;
            burst_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign req_ready = ready_c & {NREQ{reset}};
  assign win_data  = req_data[int'(win)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      ptr       <= '0;
      acc       <= '0;
      acc_upd   <= 1'b0;
      gnt_id    <= '0;
      op_count  <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      burst_cnt <= burst_n;
      acc_upd   <= grant;
      if (clr) begin
        acc <= '0;
      end else if (grant) begin
        acc    <= acc ^ win_data;
        gnt_id <= win;
        ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        if (op_count != '1) op_count <= op_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xor_acc_arbiter.sv
// Directed checks of xor_acc_arbiter: reset, single requester, round robin, lock stall,
// burst limit, clear collision and counter saturation.
module tb_xor_acc_arbiter;
  import xor_acc_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clr = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   acc;
  logic           acc_upd;
  logic [1:0]     gnt_id;
  logic [CW-1:0]  op_count;

  int ncmp = 0;
  int nerr = 0;

  xor_acc_arbiter #(.NREQ(N), .WIDTH(W), .MAXBURST(MB), .COUNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .acc       (acc),
    .acc_upd   (acc_upd),
    .gnt_id    (gnt_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, ncmp=%0d", ncmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  // Called 1 time unit after an edge; releases reset mid-cycle.
  task automatic rst_pulse();
    reset     = 1'b0;
    clr       = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    #4;
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_acc;

    // reset state, ready gated even with a valid requester
    #1 reset = 1'b0;
    req_valid = 4'b0001;
    setw(0, 8'h3C);
    #11;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_acc",   32'(acc),       32'h0);
    chk("rst_cnt",   32'(op_count),  32'h0);
    reset = 1'b1;
    repeat (3) tick();
    chk("run_acc", 32'(acc),      32'h3C);
    chk("run_cnt", 32'(op_count), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("async_acc",   32'(acc),       32'h0);
    chk("async_gnt",   32'(gnt_id),    32'h0);
    chk("async_cnt",   32'(op_count),  32'h0);
    chk("async_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b0101;
    setw(2, 8'h99);
    #1 reset = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_gnt", 32'(gnt_id), 32'h0);
    chk("post_rst_acc", 32'(acc),    32'h3C);

    // single requester
    rst_pulse();
    req_valid = 4'b0001;
    setw(0, 8'hA5);
    tick();
    chk("single_acc1", 32'(acc),     32'hA5);
    chk("single_upd1", 32'(acc_upd), 32'h1);
    setw(0, 8'h0F);
    tick();
    chk("single_acc2", 32'(acc),      32'hAA);
    chk("single_upd2", 32'(acc_upd),  32'h1);
    chk("single_gnt",  32'(gnt_id),   32'h0);
    chk("single_cnt",  32'(op_count), 32'h2);
    req_valid = '0;
    tick();
    chk("single_upd_lo", 32'(acc_upd), 32'h0);

    // round robin over four unlocked requesters
    rst_pulse();
    req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt_id), 32'(k % 4));
      if (k == 3) chk("rr_acc4", 32'(acc), 32'h0F);
    end
    chk("rr_acc5", 32'(acc),      32'h0E);
    chk("rr_cnt",  32'(op_count), 32'h5);

    // locked owner goes invalid: everyone else stalls until the lock drops
    rst_pulse();
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    setw(0, 8'h01);
    tick();
    req_valid = 4'b0010;
    setw(1, 8'h40);
    #1;
    chk("stall_ready", 32'(req_ready), 32'h0);
    tick();
    chk("stall_upd", 32'(acc_upd), 32'h0);
    chk("stall_acc", 32'(acc),     32'h01);
    req_lock = '0;
    #1;
    chk("unlock_ready", 32'(req_ready), 32'h0);
    tick();
    chk("resume_ready", 32'(req_ready), 32'h2);
    tick();
    chk("resume_gnt", 32'(gnt_id), 32'h1);
    chk("resume_acc", 32'(acc),    32'h41);

    // burst limit: four grants to req2, then ptr=3 and req1 wins
    rst_pulse();
    req_valid = 4'b0010;
    setw(1, 8'h20);
    tick();
    req_valid = 4'b0110;
    req_lock  = 4'b0100;
    setw(2, 8'h10);
    #1;
    chk("burst_ready0", 32'(req_ready), 32'h4);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("burst_gnt", 32'(gnt_id), 32'h2);
      if (j == 1) chk("burst_own_ready", 32'(req_ready), 32'h4);
    end
    chk("burst_acc",       32'(acc),       32'h20);
    chk("burst_end_ready", 32'(req_ready), 32'h2);
    tick();
    chk("burst_next_gnt", 32'(gnt_id), 32'h1);
    chk("burst_next_acc", 32'(acc),    32'h00);

    // clear collides with a valid request
    rst_pulse();
    req_valid = 4'b0001;
    setw(0, 8'hFF);
    tick();
    chk("clr_pre_acc", 32'(acc), 32'hFF);
    setw(0, 8'h55);
    clr = 1'b1;
    #1;
    chk("clr_ready", 32'(req_ready), 32'h0);
    tick();
    chk("clr_acc", 32'(acc),     32'h00);
    chk("clr_upd", 32'(acc_upd), 32'h0);
    clr = 1'b0;
    #1;
    chk("clr_next_ready", 32'(req_ready), 32'h1);
    tick();
    chk("clr_next_acc", 32'(acc),     32'h55);
    chk("clr_next_upd", 32'(acc_upd), 32'h1);

    // 17 words into a 4-bit counter
    rst_pulse();
    req_valid = 4'b0001;
    exp_acc   = '0;
    for (int k = 1; k <= 17; k++) begin
      setw(0, W'(k));
      exp_acc ^= W'(k);
      tick();
      if (k == 15) chk("sat_cnt15", 32'(op_count), 32'hF);
    end
    chk("sat_cnt", 32'(op_count), 32'hF);
    chk("sat_acc", 32'(acc),      32'(exp_acc));
    chk("sat_upd", 32'(acc_upd),  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
